// File: rtl/tff_counter_sync.sv
// rtl/tff_counter_sync.sv - WIDTH-bit T flip-flop bank / modulo up-down counter with load, tc and wrap
module tff_counter_sync #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;

  // One extra bit so MOD == 2**WIDTH is representable in the comparisons.
  localparam logic [WIDTH:0]   MOD_X = MOD[WIDTH:0];
  localparam logic [WIDTH:0]   TOP_X = MOD_X - 1'b1;
  localparam logic [WIDTH-1:0] TOP_V = TOP_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   lv_ext;
  logic             at_top;
  logic             at_zero;
  logic             over_range;

  assign q_ext      = {1'b0, q_q};
  assign lv_ext     = {1'b0, load_val};
  assign at_top     = (q_ext >= TOP_X);
  assign at_zero    = (q_q == '0);
  assign over_range = (q_ext >= MOD_X);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = (lv_ext >= MOD_X) ? TOP_V : load_val;
    end else if (en) begin
      case (mode)
        MODE_TOGGLE: q_d = q_q ^ t;
        MODE_UP: begin
          if (at_top) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          // Out-of-range values recover to the top without flagging a wrap.
          if (at_zero) begin
            q_d    = TOP_V;
            wrap_d = 1'b1;
          end else if (over_range) begin
            q_d = TOP_V;
          end else begin
            q_d = q_q - 1'b1;
          end
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= RST_V;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign tc   = ((mode == MODE_UP) && at_top) || ((mode == MODE_DOWN) && at_zero);

endmodule
